// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register file write port between the ALU
// path (A) and the load path (M). Each requester owns a DEPTH-entry FIFO; one
// head is granted per cycle into registered write-port outputs.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN (round-robin on contention);
// when undefined, M has fixed priority over A.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  output logic [4:0]  Write_Reg_Num,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        flag,
  output logic [31:0] busy_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  // Requester index 0 is A, 1 is M.
  logic [1:0]    req_valid;
  logic [4:0]    req_rd   [2];
  logic [31:0]   req_data [2];

  logic [4:0]    fifo_rd_q   [2][DEPTH];
  logic [31:0]   fifo_data_q [2][DEPTH];
  logic [PW-1:0] head_q [2];
  logic [PW-1:0] head_d [2];
  logic [PW-1:0] tail   [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];

  logic [1:0]    ready;
  logic [1:0]    store;
  logic [1:0]    nonempty;
  logic [1:0]    grant;
  logic          sel;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic          last_grant_q;  // 0 = A, 1 = M
`endif

  assign req_valid   = {m_valid, a_valid};
  assign req_rd[0]   = a_rd;
  assign req_rd[1]   = m_rd;
  assign req_data[0] = a_data;
  assign req_data[1] = m_data;

  assign a_ready = ready[0];
  assign m_ready = ready[1];

  // Readiness from pre-edge count only; held low while reset is asserted.
  always_comb begin
    ready    = 2'b00;
    store    = 2'b00;
    nonempty = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ready[i]    = !reset && (cnt_q[i] != FullCnt);
      // x0 writes complete the handshake but are dropped.
      store[i]    = req_valid[i] && ready[i] && (req_rd[i] != 5'd0);
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  // Grant selection over the FIFO heads.
  always_comb begin
    grant = nonempty;
    if (nonempty == 2'b11) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      grant = last_grant_q ? 2'b01 : 2'b10;
`else
      grant = 2'b10;
`endif
    end
  end

  assign sel       = grant[1];
  assign head_rd   = fifo_rd_q[sel][head_q[sel]];
  assign head_data = fifo_data_q[sel][head_q[sel]];

  // FIFO pointer and count next-state; push and pop on the same edge cancel.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tail[i]   = head_q[i] + cnt_q[i][PW-1:0];
      head_d[i] = head_q[i] + PW'(grant[i]);
      cnt_d[i]  = cnt_q[i] + CW'(store[i]) - CW'(grant[i]);
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        head_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          fifo_rd_q[i][k]   <= '0;
          fifo_data_q[i][k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        head_q[i] <= head_d[i];
        cnt_q[i]  <= cnt_d[i];
        if (store[i]) begin
          fifo_rd_q[i][tail[i]]   <= req_rd[i];
          fifo_data_q[i][tail[i]] <= req_data[i];
        end
      end
    end
  end

  // Registered write port; address and data hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Write_Reg_Num <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      flag          <= 1'b0;
    end else begin
      RegWrite <= |grant;
      flag     <= |grant;
      if (|grant) begin
        Write_Reg_Num <= head_rd;
        WriteData     <= head_data;
      end
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Remember the last granted requester for the contention tie-break.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (|grant) begin
      last_grant_q <= sel;
    end
  end
`endif

  // Pending-write mask over every live entry of both FIFOs.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < cnt_q[i]) begin
          busy_mask = busy_mask | (32'd1 << fifo_rd_q[i][head_q[i] + PW'(k)]);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH = 2).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_rd, m_rd;
  logic [31:0] a_data, m_data;
  logic [4:0]  Write_Reg_Num;
  logic [31:0] WriteData;
  logic        RegWrite, flag;
  logic [31:0] busy_mask;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .Write_Reg_Num(Write_Reg_Num), .WriteData(WriteData),
    .RegWrite(RegWrite), .flag(flag), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; m_valid = 1'b0;
    a_rd = '0; m_rd = '0; a_data = '0; m_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    checks++;
    if (RegWrite !== 1'b0 || flag !== 1'b0 || Write_Reg_Num !== 5'd0 ||
        WriteData !== 32'd0 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: rw=%b flag=%b wrn=%0d wd=%h busy=%h required all 0",
               RegWrite, flag, Write_Reg_Num, WriteData, busy_mask);
    end
    checks++;
    if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low: a_ready=%b m_ready=%b required 0 0", a_ready, m_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1 || m_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_high: a_ready=%b m_ready=%b required 1 1", a_ready, m_ready);
    end
    step();
  endtask

  task automatic test_single_write();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    step();
    a_valid = 1'b0;
    checks++;
    if (busy_mask !== 32'h20 || RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL single_busy: busy=%h rw=%b required 00000020 0", busy_mask, RegWrite);
    end
    step();
    checks++;
    if (RegWrite !== 1'b1 || flag !== 1'b1 || Write_Reg_Num !== 5'd5 ||
        WriteData !== 32'h1234) begin
      failures++;
      $display("FAIL single_write: rw=%b flag=%b wrn=%0d wd=%h required 1 1 5 00001234",
               RegWrite, flag, Write_Reg_Num, WriteData);
    end
    checks++;
    if (busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL single_busy_clear: busy=%h required 0", busy_mask);
    end
    step();
    checks++;
    if (RegWrite !== 1'b0 || flag !== 1'b0 || Write_Reg_Num !== 5'd5 ||
        WriteData !== 32'h1234) begin
      failures++;
      $display("FAIL single_hold: rw=%b flag=%b wrn=%0d wd=%h required 0 0 5 00001234",
               RegWrite, flag, Write_Reg_Num, WriteData);
    end
  endtask

  // M wins the first contended grant under both policies.
  task automatic test_contention();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
    m_valid = 1'b1; m_rd = 5'd2; m_data = 32'hB2;
    step();
    idle_inputs();
    checks++;
    if (busy_mask !== 32'h6 || RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL cont_busy: busy=%h rw=%b required 00000006 0", busy_mask, RegWrite);
    end
    step();
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd2 || WriteData !== 32'hB2) begin
      failures++;
      $display("FAIL cont_first: rw=%b wrn=%0d wd=%h required 1 2 000000b2",
               RegWrite, Write_Reg_Num, WriteData);
    end
    step();
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd1 || WriteData !== 32'hA1) begin
      failures++;
      $display("FAIL cont_second: rw=%b wrn=%0d wd=%h required 1 1 000000a1",
               RegWrite, Write_Reg_Num, WriteData);
    end
    step();
    checks++;
    if (RegWrite !== 1'b0 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL cont_done: rw=%b busy=%h required 0 0", RegWrite, busy_mask);
    end
  endtask

`ifdef WB_ARB_ROUND_ROBIN_EN
  // With last_grant = M, the next contention must go to A.
  task automatic test_round_robin_alt();
    do_reset();
    m_valid = 1'b1; m_rd = 5'd9; m_data = 32'h9;
    step();
    m_valid = 1'b0;
    step();  // M granted, last_grant = M
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'h10;
    m_valid = 1'b1; m_rd = 5'd11; m_data = 32'h11;
    step();
    idle_inputs();
    step();
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd10) begin
      failures++;
      $display("FAIL rr_alt_first: rw=%b wrn=%0d required 1 10", RegWrite, Write_Reg_Num);
    end
    step();
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd11) begin
      failures++;
      $display("FAIL rr_alt_second: rw=%b wrn=%0d required 1 11", RegWrite, Write_Reg_Num);
    end
  endtask
`else
  task automatic test_fixed_priority();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    m_valid = 1'b1; m_rd = 5'd3; m_data = 32'h300;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_rd = 5'(4 + i); m_data = 32'(16'h300 + 4 + i);
      step();
      checks++;
      if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'(3 + i) || busy_mask[7] !== 1'b1) begin
        failures++;
        $display("FAIL fixed_m_only[%0d]: rw=%b wrn=%0d busy7=%b required 1 %0d 1",
                 i, RegWrite, Write_Reg_Num, busy_mask[7], 3 + i);
      end
    end
    m_valid = 1'b0;
    step();
    checks++;
    if (Write_Reg_Num !== 5'd9 || busy_mask[7] !== 1'b1) begin
      failures++;
      $display("FAIL fixed_last_m: wrn=%0d busy7=%b required 9 1", Write_Reg_Num, busy_mask[7]);
    end
    step();
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd7 || WriteData !== 32'h77 ||
        busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL fixed_a_drain: rw=%b wrn=%0d wd=%h busy=%h required 1 7 00000077 0",
               RegWrite, Write_Reg_Num, WriteData, busy_mask);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd20; a_data = 32'h20;
    m_valid = 1'b1; m_rd = 5'd10; m_data = 32'h10;
    step();
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_e1: a_ready=%b required 1", a_ready);
    end
    a_rd = 5'd21; a_data = 32'h21; m_rd = 5'd11;
    step();
    checks++;
    if (a_ready !== 1'b0 || Write_Reg_Num !== 5'd10) begin
      failures++;
      $display("FAIL bp_full_e2: a_ready=%b wrn=%0d required 0 10", a_ready, Write_Reg_Num);
    end
    a_rd = 5'd22; a_data = 32'h22; m_rd = 5'd12;
    step();
    checks++;
    if (a_ready !== 1'b0 || Write_Reg_Num !== 5'd11) begin
      failures++;
      $display("FAIL bp_full_e3: a_ready=%b wrn=%0d required 0 11", a_ready, Write_Reg_Num);
    end
    m_valid = 1'b0;
    step();
    checks++;
    if (a_ready !== 1'b0 || Write_Reg_Num !== 5'd12) begin
      failures++;
      $display("FAIL bp_full_e4: a_ready=%b wrn=%0d required 0 12", a_ready, Write_Reg_Num);
    end
    step();
    checks++;
    if (a_ready !== 1'b1 || RegWrite !== 1'b1 || Write_Reg_Num !== 5'd20) begin
      failures++;
      $display("FAIL bp_a_grant: a_ready=%b rw=%b wrn=%0d required 1 1 20",
               a_ready, RegWrite, Write_Reg_Num);
    end
    step();  // held request 22 accepted here
    a_valid = 1'b0;
    checks++;
    if (Write_Reg_Num !== 5'd21) begin
      failures++;
      $display("FAIL bp_a_second: wrn=%0d required 21", Write_Reg_Num);
    end
    step();
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd22 || WriteData !== 32'h22) begin
      failures++;
      $display("FAIL bp_held: rw=%b wrn=%0d wd=%h required 1 22 00000022",
               RegWrite, Write_Reg_Num, WriteData);
    end
  endtask
`endif

  task automatic test_x0_filter();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_handshake: a_ready=%b required 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    checks++;
    if (busy_mask !== 32'd0 || RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL x0_busy: busy=%h rw=%b required 0 0", busy_mask, RegWrite);
    end
    step();
    checks++;
    if (RegWrite !== 1'b0 || flag !== 1'b0 || WriteData !== 32'd0) begin
      failures++;
      $display("FAIL x0_no_write: rw=%b flag=%b wd=%h required 0 0 0", RegWrite, flag, WriteData);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'hC;
    m_valid = 1'b1; m_rd = 5'd8;  m_data = 32'h8;
    step();
    a_rd = 5'd13; m_rd = 5'd9;
    step();
    idle_inputs();
    checks++;
    if (a_ready !== 1'b0 || RegWrite !== 1'b1 || Write_Reg_Num !== 5'd8) begin
      failures++;
      $display("FAIL mid_prefill: a_ready=%b rw=%b wrn=%0d required 0 1 8",
               a_ready, RegWrite, Write_Reg_Num);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || flag !== 1'b0 || Write_Reg_Num !== 5'd0 ||
        WriteData !== 32'd0 || busy_mask !== 32'd0 || a_ready !== 1'b0 || m_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: rw=%b flag=%b wrn=%0d wd=%h busy=%h ar=%b mr=%b required all 0",
               RegWrite, flag, Write_Reg_Num, WriteData, busy_mask, a_ready, m_ready);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1 || m_ready !== 1'b1 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL mid_release: ar=%b mr=%b busy=%h required 1 1 0", a_ready, m_ready, busy_mask);
    end
    step();
    checks++;
    if (RegWrite !== 1'b0 || Write_Reg_Num !== 5'd0) begin
      failures++;
      $display("FAIL mid_discard: rw=%b wrn=%0d required 0 0", RegWrite, Write_Reg_Num);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
`ifdef WB_ARB_ROUND_ROBIN_EN
    test_round_robin_alt();
`else
    test_fixed_priority();
    test_backpressure();
`endif
    test_x0_filter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
